pl_mem_stage: RTL

Memory-stage access unit of the 5-stage RISC-V pipeline. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register, and issues loads and stores to the data-memory bus through a req/ack handshake. It aligns store data and byte enables, and extracts and sign/zero-extends load data. It drives `ReadDataM` into MEM/WB and raises `StallM` to the hazard unit while an access is outstanding.

---
 rtl/pl_mem_pkg.sv | 48 ++++
 rtl/pl_mem_if.sv | 15 +
 rtl/pl_load_align.sv | 28 ++
 rtl/pl_mem_stage.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/pl_mem_pkg.sv
// Shared definitions for the pipeline memory stage: funct3 encodings, FSM states,
// the default bus timeout and the store-lane / alignment helpers.
package pl_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int DEFAULT_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  // Byte enables for a store; half-words are force-aligned through a[1].
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] be;
    case (f3)
      F3_B:    be = 4'b0001 << a;
      F3_H:    be = 4'b0011 << {a[1], 1'b0};
      F3_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] data;
    case (f3)
      F3_B:    data = {4{wd[7:0]}};
      F3_H:    data = {2{wd[15:0]}};
      default: data = wd;
    endcase
    return data;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a,
                                         input logic is_store);
    logic half_acc;
    half_acc = is_store ? (f3 == F3_H) : ((f3 == F3_H) || (f3 == F3_HU));
    return (half_acc && a[0]) || ((f3 == F3_W) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/pl_mem_if.sv
// Data-memory bus between the memory stage (master) and the memory (slave).
interface pl_mem_if;

  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (output req, we, addr, be, wdata, input rdata, ack);
  modport slave  (input req, we, addr, be, wdata, output rdata, ack);

endinterface

// File: rtl/pl_load_align.sv
// Combinational load extraction: selects the addressed byte/half of the bus word
// and sign- or zero-extends it according to funct3.
module pl_load_align
  import pl_mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{offset_i, 3'b000} +: 8];
    half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
    case (funct3_i)
      F3_B:    result_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   result_o = {24'h0, byte_sel};
      F3_H:    result_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   result_o = {16'h0, half_sel};
      F3_W:    result_o = word_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/pl_mem_stage.sv
// RISC-V M-stage access unit: issues loads/stores over a req/ack bus and stalls the
// pipeline while an access is outstanding. Define PL_MEM_MISALIGN_TRAP_EN to trap misaligned accesses.
module pl_mem_stage
  import pl_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [2:0]  funct3M,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        TimeoutM,
  output logic        MisalignM,
  pl_mem_if.master    dmem
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  mem_state_t  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] rdata_q, rdata_d;
  logic        timeout_q, timeout_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;

  logic        access;
  logic        mis_trap;
  logic [31:0] load_data;

  assign access = MemReadM | MemWriteM;

`ifdef PL_MEM_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
  assign mis_trap  = is_misaligned(funct3M, ALUResultM[1:0], MemWriteM);
  assign MisalignM = misalign_q;
`else
  assign mis_trap  = 1'b0;
  assign MisalignM = 1'b0;
`endif

  pl_load_align u_load_align (
    .word_i   (dmem.rdata),
    .offset_i (off_q),
    .funct3_i (f3_q),
    .result_o (load_data)
  );

  always_comb begin
    // NOTE: every _d defaults to its _q before the case, so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    off_d     = off_q;
    f3_d      = f3_q;
    rdata_d   = rdata_q;
    timeout_d = timeout_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
`ifdef PL_MEM_MISALIGN_TRAP_EN
    misalign_d = misalign_q;
`endif

    case (state_q)
      IDLE: begin
        if (access) begin
          off_d = ALUResultM[1:0];
          f3_d  = funct3M;
          if (mis_trap) begin
            state_d = DONE;
            rdata_d = '0;
`ifdef PL_MEM_MISALIGN_TRAP_EN
            misalign_d = 1'b1;
`endif
          end else begin
            state_d = WAIT;
            cnt_d   = '0;
            req_d   = 1'b1;
            we_d    = MemWriteM;
            addr_d  = {ALUResultM[31:2], 2'b00};
            be_d    = MemWriteM ? store_be(funct3M, ALUResultM[1:0]) : 4'b1111;
            wdata_d = store_wdata(funct3M, WriteDataM);
          end
        end
      end

      WAIT: begin
        if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        // Ack is checked first so it wins over a timeout expiring in the same cycle.
        if (dmem.ack) begin
          if (!we_q) rdata_d = load_data;
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = DONE;
        end else if (cnt_q >= TIMEOUT_LAST) begin
          rdata_d   = '0;
          timeout_d = 1'b1;
          req_d     = 1'b0;
          we_d      = 1'b0;
          state_d   = DONE;
        end
      end

      DONE: begin
        state_d   = IDLE;
        timeout_d = 1'b0;
`ifdef PL_MEM_MISALIGN_TRAP_EN
        misalign_d = 1'b0;
`endif
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      off_q     <= '0;
      f3_q      <= '0;
      rdata_q   <= '0;
      timeout_q <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
`ifdef PL_MEM_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking updates so every register samples the pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      off_q     <= off_d;
      f3_q      <= f3_d;
      rdata_q   <= rdata_d;
      timeout_q <= timeout_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
`ifdef PL_MEM_MISALIGN_TRAP_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  assign StallM     = access & (state_q != DONE);
  assign ReadDataM  = rdata_q;
  assign TimeoutM   = timeout_q;
  assign dmem.req   = req_q;
  assign dmem.we    = we_q;
  assign dmem.addr  = addr_q;
  assign dmem.be    = be_q;
  assign dmem.wdata = wdata_q;

endmodule
